fast_field_decoder: RTL and testbench
=====================================

Name: fast_field_decoder

Overview:
Second-generation FAST field decoder. It arbitrates across NUM_PATHS stop-bit-encoded byte lanes and assembles one field at a time into a VAL_W-bit integer, signed or unsigned. It then applies the FAST operator (none/const/copy/default/delta/increment) against a per-slot dictionary. It sits between the packet lane splitter and the message assembler, and emits one decoded field per accepted descriptor with msgid/field-number tags.

Parameters:
NUM_PATHS, 4, number of input byte lanes
VAL_W, 64, decoded value width
MAX_BYTES, 10, max stop-bit bytes per field
NUM_SLOTS, 16, dictionary entries
MSGID_W, 21, message ID width
FNUM_W, 8, field number width

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
in_valid  in  NUM_PATHS  per-lane byte valid
in_byte  in  NUM_PATHS x 8  per-lane byte; bit7 = stop bit
in_ready  out  NUM_PATHS  per-lane byte accept
desc_valid/desc_ready  in/out  1/1  field descriptor handshake
desc_type  in  1  0 = uint, 1 = int
desc_op  in  3  0 none, 1 const, 2 copy, 3 default, 4 delta, 5 increment
desc_pmap  in  1  presence-map bit for this field
desc_slot  in  clog2(NUM_SLOTS)  dictionary slot
desc_const  in  VAL_W  constant/initial value
desc_msgid  in  MSGID_W  message ID tag
desc_fnum  in  FNUM_W  field number tag
dict_clear  in  1  FAST dictionary reset (invalidate all slots)
out_valid/out_ready  out/in  1/1  decoded-field handshake
out_value  out  VAL_W  decoded value
out_msgid  out  MSGID_W  tag
out_fnum  out  FNUM_W  tag
out_path  out  clog2(NUM_PATHS)  lane the bytes came from (0 if none consumed)
err_valid  out  1  one-cycle error pulse
err_code  out  2  0 overflow, 1 overlong, 2 empty-dictionary

Behaviour:
- Reset: FSM=IDLE; all outputs 0; all slot valid bits 0; rr pointer = NUM_PATHS-1 (path 0 wins first). Reset mid-field abandons the field silently.
- FSM states: IDLE -> ARB -> COLLECT -> APPLY -> OUT -> IDLE; COLLECT -> DRAIN -> IDLE on overlong.
- IDLE: desc_ready=1; the descriptor is latched on accept.
- Field needs bytes iff op in {none, delta}, or op in {copy, default, increment} with pmap=1. Const never consumes bytes. No-byte fields go IDLE -> APPLY directly.
- ARB: round-robin from last granted path+1 among in_valid. The winner is locked; stay in ARB while no lane is valid.
- COLLECT/DRAIN: in_ready asserted only for the locked lane, combinationally. One byte per cycle when in_valid.
  - acc = (acc<<7) | byte[6:0].
  - For int, the first byte's bit6=1 preloads acc to all-ones (sign extension).
  - Overflow is flagged (sticky) if any bit shifted out of acc differs from the sign fill.
- Stop byte (bit7=1) -> APPLY. Reaching MAX_BYTES bytes without a stop bit: err pulse code 1, enter DRAIN. DRAIN consumes bytes until and including the stop byte, then returns to IDLE with no output.
- APPLY (1 cycle), arithmetic mod 2^VAL_W:
  - none: acc.
  - const: desc_const.
  - copy: pmap ? acc (store) : dict.
  - default: pmap ? acc : desc_const; no store.
  - increment: pmap ? acc (store) : dict+1 (store).
  - delta: (slot valid ? dict : desc_const) + acc (store).
- Dictionary errors: copy or increment with pmap=0 on an invalid slot gives err code 2, and out_value=0 is still emitted. A sticky overflow gives err code 0 and no output (return to IDLE).
- Stores set the slot valid bit. dict_clear clears all valid bits in 1 cycle and wins over a same-cycle store.
- OUT: output registers load at the end of APPLY, so out_valid rises the following cycle. Outputs hold stable until out_ready; return to IDLE on the handshake.
- Latency for a k-byte field, descriptor accepted at cycle T with lane already valid: ARB at T+1, bytes at T+2..T+1+k, APPLY at T+2+k, out_valid at T+3+k.
- Throughput: one field per (k+4) cycles minimum; no overlap.

Test Plan:
- uint/none, lane0 bytes 0x39,0x45,0xA3 -> out_value=942755 (0xE62A3), out_path=0, latency 6 cycles from desc accept to out_valid.
- int/none, single byte 0xFF -> out_value=all-ones (-1); byte 0x80 -> 0.
- copy, slot 3, pmap=1, byte 0x85 -> 5. Then copy pmap=0 -> 5 with no in_ready asserted. Then increment pmap=0 -> 6. Then dict_clear, copy pmap=0 -> err_code=2, out_value=0.
- delta, empty slot 7, desc_const=100, byte 0x83 -> 103. Repeat with byte 0x81 -> 104.
- 11 bytes of 0x01 then 0x80 on lane1 -> err_code=1 after the 10th byte, all 12 bytes consumed, no out_valid, next descriptor decodes normally.
- Lanes 0 and 2 continuously valid, three descriptors -> out_path 0, 2, 0. out_ready held low 5 cycles -> outputs stable, no bytes consumed meanwhile.

Source files
------------

// File: rtl/fast_field_decoder_if.sv
// fast_field_decoder_if: byte-lane, descriptor and decoded-field signals of the FAST field decoder
interface fast_field_decoder_if #(
  parameter int NUM_PATHS = 4,
  parameter int VAL_W = 64,
  parameter int NUM_SLOTS = 16,
  parameter int MSGID_W = 21,
  parameter int FNUM_W = 8
);
  localparam int PW = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  logic [NUM_PATHS-1:0] in_valid;
  logic [NUM_PATHS-1:0][7:0] in_byte;
  logic [NUM_PATHS-1:0] in_ready;
  logic desc_valid;
  logic desc_ready;
  logic desc_type;
  logic [2:0] desc_op;
  logic desc_pmap;
  logic [SW-1:0] desc_slot;
  logic [VAL_W-1:0] desc_const;
  logic [MSGID_W-1:0] desc_msgid;
  logic [FNUM_W-1:0] desc_fnum;
  logic dict_clear;
  logic out_valid;
  logic out_ready;
  logic [VAL_W-1:0] out_value;
  logic [MSGID_W-1:0] out_msgid;
  logic [FNUM_W-1:0] out_fnum;
  logic [PW-1:0] out_path;
  logic err_valid;
  logic [1:0] err_code;
  modport master (
    output in_valid, in_byte, desc_valid, desc_type, desc_op, desc_pmap, desc_slot, desc_const,
           desc_msgid, desc_fnum, dict_clear, out_ready,
    input  in_ready, desc_ready, out_valid, out_value, out_msgid, out_fnum, out_path, err_valid, err_code
  );
  modport slave (
    input  in_valid, in_byte, desc_valid, desc_type, desc_op, desc_pmap, desc_slot, desc_const,
           desc_msgid, desc_fnum, dict_clear, out_ready,
    output in_ready, desc_ready, out_valid, out_value, out_msgid, out_fnum, out_path, err_valid, err_code
  );
endinterface

// File: rtl/fast_field_decoder.sv
// fast_field_decoder: round-robin stop-bit field collector with FAST operator/dictionary stage
module fast_field_decoder #(
  parameter int NUM_PATHS = 4,
  parameter int VAL_W = 64,
  parameter int MAX_BYTES = 10,
  parameter int NUM_SLOTS = 16,
  parameter int MSGID_W = 21,
  parameter int FNUM_W = 8
) (
  input logic clk,
  input logic rstn,
  fast_field_decoder_if.slave bus
);
  localparam int PW = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_ARB = 3'd1, S_COLLECT = 3'd2, S_APPLY = 3'd3, S_OUT = 3'd4, S_DRAIN = 3'd5;
  localparam logic [2:0] OP_NONE = 3'd0, OP_CONST = 3'd1, OP_COPY = 3'd2, OP_DEFAULT = 3'd3, OP_DELTA = 3'd4, OP_INCR = 3'd5;
  logic [2:0] state_q, op_q;
  logic [PW-1:0] rr_q, lane_q, grant, cand;
  logic found, type_q, pmap_q, sign_q, ovf_q;
  logic [SW-1:0] slot_q;
  logic [VAL_W-1:0] const_q, acc_q, base, acc_d, res;
  logic [MSGID_W-1:0] msgid_q;
  logic [FNUM_W-1:0] fnum_q;
  logic [CW-1:0] cnt_q;
  logic [VAL_W-1:0] dict_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] dvld_q;
  logic out_valid_q, err_valid_q;
  logic [VAL_W-1:0] out_value_q;
  logic [MSGID_W-1:0] out_msgid_q;
  logic [FNUM_W-1:0] out_fnum_q;
  logic [PW-1:0] out_path_q;
  logic [1:0] err_code_q;
  logic [7:0] b_in;
  logic busy, take, sgn, ovf_now, needs, store, derr, do_store, dok;
  logic [VAL_W-1:0] dval;
  assign busy = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign b_in = bus.in_byte[lane_q];
  assign take = busy && bus.in_valid[lane_q];
  assign bus.in_ready = busy ? (NUM_PATHS'(1) << lane_q) : '0;
  assign bus.desc_ready = state_q == S_IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_msgid = out_msgid_q;
  assign bus.out_fnum = out_fnum_q;
  assign bus.out_path = out_path_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code = err_code_q;
  assign needs = (bus.desc_op == OP_NONE) || (bus.desc_op == OP_DELTA) ||
                 (bus.desc_pmap && (bus.desc_op == OP_COPY || bus.desc_op == OP_DEFAULT || bus.desc_op == OP_INCR));
  // the first int byte with bit6 set preloads the accumulator with the sign
  assign sgn = (cnt_q == '0) ? (type_q & b_in[6]) : sign_q;
  assign base = (cnt_q == '0) ? {VAL_W{sgn}} : acc_q;
  assign acc_d = {base[VAL_W-8:0], b_in[6:0]};
  assign ovf_now = base[VAL_W-1 -: 7] != {7{sgn}};
  assign dval = dict_q[slot_q];
  assign dok = dvld_q[slot_q];
  assign do_store = (state_q == S_APPLY) && !ovf_q && store;
  always_comb begin
    grant = rr_q;
    found = 1'b0;
    cand = '0;
    for (int i = NUM_PATHS; i >= 1; i--) begin
      cand = PW'((int'(rr_q) + i) % NUM_PATHS);
      if (bus.in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    res = acc_q;
    store = 1'b0;
    derr = 1'b0;
    case (op_q)
      OP_CONST: res = const_q;
      OP_COPY: begin
        res = pmap_q ? acc_q : (dok ? dval : '0);
        store = pmap_q;
        derr = !pmap_q && !dok;
      end
      OP_DEFAULT: res = pmap_q ? acc_q : const_q;
      OP_INCR: begin
        res = pmap_q ? acc_q : (dok ? dval + VAL_W'(1) : '0);
        store = pmap_q || dok;
        derr = !pmap_q && !dok;
      end
      OP_DELTA: begin
        res = (dok ? dval : const_q) + acc_q;
        store = 1'b1;
      end
      default: res = acc_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) dvld_q <= '0;
    else if (bus.dict_clear) dvld_q <= '0;
    else if (do_store) dvld_q[slot_q] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (do_store) dict_q[slot_q] <= res;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rr_q <= PW'(NUM_PATHS - 1);
      lane_q <= '0;
      type_q <= 1'b0;
      op_q <= '0;
      pmap_q <= 1'b0;
      slot_q <= '0;
      const_q <= '0;
      msgid_q <= '0;
      fnum_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      sign_q <= 1'b0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_msgid_q <= '0;
      out_fnum_q <= '0;
      out_path_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q <= '0;
    end else begin
      err_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.desc_valid) begin
          type_q <= bus.desc_type;
          op_q <= bus.desc_op;
          pmap_q <= bus.desc_pmap;
          slot_q <= bus.desc_slot;
          const_q <= bus.desc_const;
          msgid_q <= bus.desc_msgid;
          fnum_q <= bus.desc_fnum;
          acc_q <= '0;
          cnt_q <= '0;
          sign_q <= 1'b0;
          ovf_q <= 1'b0;
          lane_q <= '0;
          state_q <= needs ? S_ARB : S_APPLY;
        end
        S_ARB: if (found) begin
          lane_q <= grant;
          rr_q <= grant;
          state_q <= S_COLLECT;
        end
        S_COLLECT: if (take) begin
          acc_q <= acc_d;
          sign_q <= sgn;
          cnt_q <= cnt_q + 1'b1;
          ovf_q <= ovf_q | ovf_now;
          if (b_in[7]) state_q <= S_APPLY;
          else if (cnt_q == CW'(MAX_BYTES - 1)) begin
            err_valid_q <= 1'b1;
            err_code_q <= 2'd1;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: if (take && b_in[7]) state_q <= S_IDLE;
        S_APPLY: if (ovf_q) begin
          err_valid_q <= 1'b1;
          err_code_q <= 2'd0;
          state_q <= S_IDLE;
        end else begin
          out_valid_q <= 1'b1;
          out_value_q <= res;
          out_msgid_q <= msgid_q;
          out_fnum_q <= fnum_q;
          out_path_q <= lane_q;
          err_valid_q <= derr;
          err_code_q <= derr ? 2'd2 : err_code_q;
          state_q <= S_OUT;
        end
        S_OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fast_field_decoder.sv
// tb_fast_field_decoder: directed vectors, expected fields queued at issue and checked by a monitor
module tb_fast_field_decoder;
  localparam int NP = 4;
  typedef struct {
    logic [63:0] v;
    logic [1:0] p;
    logic [20:0] m;
    logic [7:0] f;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  fast_field_decoder_if bus ();
  fast_field_decoder dut (.clk(clk), .rstn(rstn), .bus(bus));
  exp_t exp_q[$];
  logic [1:0] err_q[$];
  logic [7:0] lq [NP][$];
  int taken [NP] = '{default: 0};
  int n_chk = 0, n_fail = 0, ncyc = 0, rdy_cnt = 0, t_acc = 0, t_rise = 0;
  logic ov_prev = 1'b0;
  logic [7:0] fnum_ctr = 8'd0;
  logic [NP-1:0] fire;

  // lane feeders: a lane is valid while its queue holds bytes
  always begin
    for (int l = 0; l < NP; l++) begin
      bus.in_valid[l] = lq[l].size() != 0;
      bus.in_byte[l] = (lq[l].size() != 0) ? lq[l][0] : 8'h00;
    end
    @(negedge clk);
    fire = bus.in_valid & bus.in_ready;
    @(posedge clk);
    #1;
    for (int l = 0; l < NP; l++) begin
      if (fire[l]) begin
        void'(lq[l].pop_front());
        taken[l]++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [1:0] ec;
    ncyc++;
    if (|bus.in_ready) rdy_cnt++;
    if (bus.desc_valid && bus.desc_ready) t_acc = ncyc;
    if (bus.out_valid && !ov_prev) t_rise = ncyc;
    ov_prev = bus.out_valid;
    if (bus.out_valid && bus.out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out unexpected: got value %h path %0d fnum %0d, want no output", bus.out_value, bus.out_path, bus.out_fnum);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_value !== e.v || bus.out_path !== e.p || bus.out_msgid !== e.m || bus.out_fnum !== e.f) begin
          n_fail++;
          $display("FAIL out field %0d: got value %h path %0d msgid %h fnum %0d, want value %h path %0d msgid %h fnum %0d",
                   e.f, bus.out_value, bus.out_path, bus.out_msgid, bus.out_fnum, e.v, e.p, e.m, e.f);
        end
      end
    end
    if (bus.err_valid === 1'b1) begin
      n_chk++;
      if (err_q.size() == 0) begin
        n_fail++;
        $display("FAIL err unexpected: got code %0d, want no error", bus.err_code);
      end else begin
        ec = err_q.pop_front();
        if (bus.err_code !== ec) begin
          n_fail++;
          $display("FAIL err code: got %0d, want %0d", bus.err_code, ec);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic push(input int l, input logic [7:0] b);
    lq[l].push_back(b);
  endtask

  task automatic send(input logic t, input logic [2:0] op, input logic pm, input logic [3:0] sl, input logic [63:0] c,
                      input bit eo, input logic [63:0] ev, input logic [1:0] ep, input bit ee, input logic [1:0] ec);
    exp_t e;
    logic hs;
    int k;
    fnum_ctr++;
    bus.desc_type = t;
    bus.desc_op = op;
    bus.desc_pmap = pm;
    bus.desc_slot = sl;
    bus.desc_const = c;
    bus.desc_fnum = fnum_ctr;
    bus.desc_msgid = 21'h12345 ^ {13'h0, fnum_ctr};
    bus.desc_valid = 1'b1;
    if (eo) begin
      e.v = ev;
      e.p = ep;
      e.m = 21'h12345 ^ {13'h0, fnum_ctr};
      e.f = fnum_ctr;
      exp_q.push_back(e);
    end
    if (ee) err_q.push_back(ec);
    hs = 1'b0;
    k = 0;
    while (!hs && k < 100) begin
      @(negedge clk);
      hs = bus.desc_ready;
      step();
      k++;
    end
    bus.desc_valid = 1'b0;
    if (!hs) begin
      n_chk++;
      n_fail++;
      $display("FAIL desc accept %0d: got no desc_ready in 100 cycles, want accept", fnum_ctr);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d outputs and %0d errors pending, want 0", exp_q.size(), err_q.size());
      exp_q.delete();
      err_q.delete();
    end
    repeat (4) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0, k;
    bus.desc_valid = 1'b0;
    bus.desc_type = 1'b0;
    bus.desc_op = 3'd0;
    bus.desc_pmap = 1'b0;
    bus.desc_slot = 4'd0;
    bus.desc_const = 64'd0;
    bus.desc_msgid = 21'd0;
    bus.desc_fnum = 8'd0;
    bus.dict_clear = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_value", bus.out_value, 0);
    check("reset err_valid", bus.err_valid, 0);
    check("reset in_ready", bus.in_ready, 0);
    check("reset desc_ready", bus.desc_ready, 1);
    step();
    rstn = 1'b1;
    // uint 3-byte field and its latency
    push(0, 8'h39); push(0, 8'h45); push(0, 8'hA3);
    step(); step();
    send(0, 3'd0, 1, 4'd0, 64'd0, 1, 64'd942755, 2'd0, 0, 2'd0);
    wait_done();
    check("latency accept->out_valid", 64'(t_rise - t_acc), 64'd6);
    // signed fields
    push(0, 8'hFF); push(0, 8'h80); push(0, 8'h7F); push(0, 8'h80);
    step(); step();
    send(1, 3'd0, 1, 4'd0, 64'd0, 1, {64{1'b1}}, 2'd0, 0, 2'd0);
    send(1, 3'd0, 1, 4'd0, 64'd0, 1, 64'd0, 2'd0, 0, 2'd0);
    send(1, 3'd0, 1, 4'd0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 0, 2'd0);
    wait_done();
    // widest uint that fits, then one that overflows
    push(0, 8'h01);
    for (int i = 0; i < 8; i++) push(0, 8'h7F);
    push(0, 8'hFF);
    for (int i = 0; i < 9; i++) push(0, 8'h7F);
    push(0, 8'hFF);
    step(); step();
    send(0, 3'd0, 1, 4'd0, 64'd0, 1, {64{1'b1}}, 2'd0, 0, 2'd0);
    send(0, 3'd0, 1, 4'd0, 64'd0, 0, 64'd0, 2'd0, 1, 2'd0);
    wait_done();
    // const and default without bytes
    send(0, 3'd1, 0, 4'd0, 64'hDEAD, 1, 64'hDEAD, 2'd0, 0, 2'd0);
    send(0, 3'd3, 0, 4'd0, 64'd77, 1, 64'd77, 2'd0, 0, 2'd0);
    wait_done();
    // copy / increment on slot 3
    push(0, 8'h85);
    step(); step();
    send(0, 3'd2, 1, 4'd3, 64'd0, 1, 64'd5, 2'd0, 0, 2'd0);
    wait_done();
    r0 = rdy_cnt;
    send(0, 3'd2, 0, 4'd3, 64'd0, 1, 64'd5, 2'd0, 0, 2'd0);
    wait_done();
    check("copy pmap0 in_ready cycles", 64'(rdy_cnt - r0), 64'd0);
    send(0, 3'd5, 0, 4'd3, 64'd0, 1, 64'd6, 2'd0, 0, 2'd0);
    wait_done();
    bus.dict_clear = 1'b1;
    step();
    bus.dict_clear = 1'b0;
    send(0, 3'd2, 0, 4'd3, 64'd0, 1, 64'd0, 2'd0, 1, 2'd2);
    wait_done();
    // delta on empty slot 7, then on the stored value
    push(0, 8'h83); push(0, 8'h81);
    step(); step();
    send(0, 3'd4, 1, 4'd7, 64'd100, 1, 64'd103, 2'd0, 0, 2'd0);
    send(0, 3'd4, 1, 4'd7, 64'd100, 1, 64'd104, 2'd0, 0, 2'd0);
    wait_done();
    // overlong field on lane 1, then a normal field
    t0 = taken[1];
    for (int i = 0; i < 11; i++) push(1, 8'h01);
    push(1, 8'h80);
    step(); step();
    send(0, 3'd0, 1, 4'd0, 64'd0, 0, 64'd0, 2'd0, 1, 2'd1);
    wait_done();
    check("overlong bytes consumed", 64'(taken[1] - t0), 64'd12);
    push(0, 8'h85);
    step(); step();
    send(0, 3'd0, 1, 4'd0, 64'd0, 1, 64'd5, 2'd0, 0, 2'd0);
    wait_done();
    // park the round-robin pointer on lane 3
    push(3, 8'h84);
    step(); step();
    send(0, 3'd0, 1, 4'd0, 64'd0, 1, 64'd4, 2'd3, 0, 2'd0);
    wait_done();
    // lanes 0 and 2 both valid: grants 0, 2, 0; last output stalled
    push(0, 8'h81); push(0, 8'h83); push(2, 8'h82);
    step(); step();
    send(0, 3'd0, 1, 4'd0, 64'd0, 1, 64'd1, 2'd0, 0, 2'd0);
    send(0, 3'd0, 1, 4'd0, 64'd0, 1, 64'd2, 2'd2, 0, 2'd0);
    wait_done();
    bus.out_ready = 1'b0;
    send(0, 3'd0, 1, 4'd0, 64'd0, 1, 64'd3, 2'd0, 0, 2'd0);
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("stall out_valid", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall out_value", bus.out_value, 64'd3);
      check("stall out_path", bus.out_path, 0);
      check("stall in_ready", bus.in_ready, 0);
    end
    step();
    bus.out_ready = 1'b1;
    wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
